// File: rtl/stage_if_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// stage_if_prefetch_pkg
//   Shared constants for the prefetching instruction-fetch stage:
//   fetch FSM state encodings and the size of one instruction in bytes.
// -----------------------------------------------------------------------------
package stage_if_prefetch_pkg;

  // Fetch FSM states (kept as plain constants for legacy-tool compatibility).
  localparam logic [1:0] IF_IDLE = 2'd0;  // free to issue a read
  localparam logic [1:0] IF_WAIT = 2'd1;  // read outstanding, result wanted
  localparam logic [1:0] IF_DROP = 2'd2;  // read outstanding, result stale

  // Byte distance between consecutive instructions.
  localparam int INST_BYTES = 4;

endpackage

// File: rtl/stage_if_prefetch_if_fifo.sv
// -----------------------------------------------------------------------------
// stage_if_prefetch_if_fifo
//   Synchronous FIFO holding fetched {pc, instruction} entries.
//   Head entry is always visible on rdata; flush empties it in one cycle.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     flush           discard all entries (wins over push/pop)
//     push, wdata     write one entry (ignored when full)
//     pop             remove head entry (ignored when empty)
//     rdata           head entry (undefined content when empty)
//     count           number of stored entries, 0..DEPTH
//     empty, full     occupancy flags
// -----------------------------------------------------------------------------
module stage_if_prefetch_if_fifo
  import stage_if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle, or push+pop cancel out
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count,
  // and leaving the array reset-free lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stage_if_prefetch.sv
// -----------------------------------------------------------------------------
// stage_if_prefetch
//   Clocked instruction-fetch stage with its own fetch PC and a prefetch
//   queue. Issues one read at a time over the single-port memory handshake,
//   buffers up to DEPTH {pc, instruction} pairs and hands them to ID under a
//   valid/stall handshake. A branch/jump redirect flushes the queue and
//   restarts fetching at the new (word-aligned) PC.
//
//   Build option:
//     IF_BYPASS_EN  when defined, an instruction returning into an empty
//                   queue is presented to ID in the same cycle.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     stall_i                   ID not accepting this cycle
//     redirect_i, redirect_pc_i branch/jump taken and its target
//     mem_busy, mem_done        memory handshake inputs
//     mem_data_i                returned instruction (valid with mem_done)
//     mem_re, mem_addr_o        read request and address
//     pc_o, inst_o, valid_o     instruction presented to ID
//     stallreq                  ID starved (no valid instruction)
// -----------------------------------------------------------------------------
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_data_i,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o,
  output logic              stallreq
);

  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam int                ENT_W      = ADDR_W + INST_W;
  localparam logic [CNT_W:0]    DEPTH_OCC  = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;   // next address to request
  logic [ADDR_W-1:0] req_pc;     // address of the outstanding request

  logic              inflight;
  logic [CNT_W:0]    occupancy;
  logic              q_full;
  logic              issue;
  logic              accept;
  logic              push;
  logic              pop;

  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;

  // A queue slot is reserved while a read is in flight, so a returning
  // instruction always has room and the FIFO never sees a refused push.
  assign inflight  = (state != IF_IDLE);
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign q_full    = full || (occupancy >= DEPTH_OCC);

  // Request is combinational on mem_busy so it is raised in the first cycle
  // the port is free; it is held off during reset and on a redirect.
  assign issue      = !rst && (state == IF_IDLE) && !mem_busy && !redirect_i && !q_full;
  assign mem_re     = issue;
  assign mem_addr_o = issue ? fetch_pc : '0;

  // Only a response to a live (non-dropped) request is kept.
  assign accept = !rst && (state == IF_WAIT) && mem_done && !redirect_i;

  stage_if_prefetch_if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata ({req_pc, mem_data_i}),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign head_pc   = head[ENT_W-1:INST_W];
  assign head_inst = head[INST_W-1:0];
  assign pop       = !empty && !stall_i;

`ifdef IF_BYPASS_EN
  logic bypass;

  // Returning instruction shown directly when nothing older is queued; it is
  // only enqueued if ID does not take it this cycle.
  assign bypass  = accept && empty;
  assign push    = accept && !(bypass && !stall_i);
  assign valid_o = !empty || bypass;
  assign pc_o    = bypass ? req_pc     : (empty ? '0 : head_pc);
  assign inst_o  = bypass ? mem_data_i : (empty ? '0 : head_inst);
`else
  assign push    = accept;
  assign valid_o = !empty;
  assign pc_o    = empty ? '0 : head_pc;
  assign inst_o  = empty ? '0 : head_inst;
`endif

  assign stallreq = !valid_o && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IF_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & ALIGN_MASK;
      // An outstanding read that is not completing now must be drained.
      state    <= (inflight && !mem_done) ? IF_DROP : IF_IDLE;
    end else begin
      case (state)
        IF_IDLE: begin
          if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_STEP;
            state    <= IF_WAIT;
          end
        end
        IF_WAIT: if (mem_done) state <= IF_IDLE;
        IF_DROP: if (mem_done) state <= IF_IDLE;
        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_stage_if_prefetch
//   Directed bench for stage_if_prefetch (default build, DEPTH=4,
//   RESET_PC=0). A behavioural memory answers each read two cycles after
//   the request with a data word derived from the address. Inputs change
//   1 time unit after the rising edge; outputs are sampled on the falling
//   edge.
// -----------------------------------------------------------------------------
module tb_stage_if_prefetch;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_busy;
  logic        mem_done;
  logic [31:0] mem_data_i;
  logic        mem_re;
  logic [31:0] mem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        stallreq;

  int total = 0;
  int bad   = 0;

  logic        mem_pend      = 1'b0;
  int          mem_dly       = 0;
  logic [31:0] mem_pend_addr = '0;

  stage_if_prefetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_busy      (mem_busy),
    .mem_done      (mem_done),
    .mem_data_i    (mem_data_i),
    .mem_re        (mem_re),
    .mem_addr_o    (mem_addr_o),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .stallreq      (stallreq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'hA5A5_0000;
  endfunction

  // Memory: request seen in cycle T -> mem_done pulse in cycle T+MEM_LAT.
  initial begin
    mem_done   = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_done = 1'b0;
      if (mem_pend) begin
        if (mem_dly <= 1) begin
          mem_done   = 1'b1;
          mem_data_i = inst_of(mem_pend_addr);
          mem_pend   = 1'b0;
        end else begin
          mem_dly--;
        end
      end
      @(negedge clk);
      if (mem_re === 1'b1) begin
        mem_pend      = 1'b1;
        mem_dly       = MEM_LAT;
        mem_pend_addr = mem_addr_o;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for three edges (long enough for any stale reply to land),
  // then releases it; returns at the start of the first post-reset cycle.
  task automatic do_reset(input logic st, input logic busy);
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    stall_i       = st;
    mem_busy      = busy;
    repeat (3) next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    stall_i       = 1'b0;
    mem_busy      = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    total++;
    if (mem_re !== 1'b0 || valid_o !== 1'b0 || stallreq !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got re=%b valid=%b stallreq=%b exp 0/0/0", mem_re, valid_o, stallreq);
    end
    total++;
    if (pc_o !== 32'h0 || inst_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got pc=%h inst=%h exp 0/0", pc_o, inst_o);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mem_re !== 1'b1 || mem_addr_o !== 32'h0 || stallreq !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_req got re=%b addr=%h stallreq=%b exp 1/00000000/1", mem_re, mem_addr_o, stallreq);
    end
    next_cycle();
  endtask

  // Free-running fetch: one instruction every 3 cycles (issue, wait, done).
  task automatic test_stream();
    logic        exp_re, exp_v;
    logic [31:0] exp_addr, exp_pc;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      exp_re   = (i % 3 == 0);
      exp_addr = 32'(4 * (i / 3));
      exp_v    = (i >= 3) && (i % 3 == 0);
      exp_pc   = 32'(4 * (i / 3 - 1));
      total++;
      if (mem_re !== exp_re || (exp_re && mem_addr_o !== exp_addr)) begin
        bad++;
        $display("FAIL stream_req cyc=%0d got re=%b addr=%h exp re=%b addr=%h", i, mem_re, mem_addr_o, exp_re, exp_addr);
      end
      total++;
      if (valid_o !== exp_v || stallreq !== !exp_v ||
          (exp_v && (pc_o !== exp_pc || inst_o !== inst_of(exp_pc)))) begin
        bad++;
        $display("FAIL stream_out cyc=%0d got v=%b sr=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                 i, valid_o, stallreq, pc_o, inst_o, exp_v, exp_pc, inst_of(exp_pc));
      end
      next_cycle();
    end
  endtask

  // ID stalled: queue fills to 4, fetching stops; release drains 4 back to back.
  task automatic test_stall_fill();
    logic        exp_re;
    logic [31:0] rel_pc   [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h0};
    logic        rel_v    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        rel_re   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] rel_addr [6] = '{32'h0, 32'h10, 32'h0, 32'h0, 32'h14, 32'h0};
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_re = (i % 3 == 0) && (i <= 9);
      total++;
      if (mem_re !== exp_re || (exp_re && mem_addr_o !== 32'(4 * (i / 3)))) begin
        bad++;
        $display("FAIL fill_req cyc=%0d got re=%b addr=%h exp re=%b addr=%h", i, mem_re, mem_addr_o, exp_re, 32'(4 * (i / 3)));
      end
      if (i >= 3) begin
        total++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
          bad++;
          $display("FAIL fill_head cyc=%0d got v=%b pc=%h exp v=1 pc=00000000", i, valid_o, pc_o);
        end
      end
      next_cycle();
    end
    stall_i = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      total++;
      if (valid_o !== rel_v[j] || (rel_v[j] && (pc_o !== rel_pc[j] || inst_o !== inst_of(rel_pc[j])))) begin
        bad++;
        $display("FAIL drain_out step=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h", j, valid_o, pc_o, inst_o, rel_v[j], rel_pc[j]);
      end
      total++;
      if (mem_re !== rel_re[j] || (rel_re[j] && mem_addr_o !== rel_addr[j])) begin
        bad++;
        $display("FAIL drain_req step=%0d got re=%b addr=%h exp re=%b addr=%h", j, mem_re, mem_addr_o, rel_re[j], rel_addr[j]);
      end
      next_cycle();
    end
  endtask

  // Redirect while a read is outstanding (no same-cycle reply) -> DROP.
  task automatic test_redirect_wait();
    do_reset(1'b1, 1'b0);
    repeat (6) next_cycle();
    @(negedge clk);                       // C6: queue holds pc 0 and 4
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
      bad++;
      $display("FAIL rdw_pre got v=%b pc=%h exp v=1 pc=00000000", valid_o, pc_o);
    end
    next_cycle();                         // C7: WAIT for pc 8
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    next_cycle();                         // C8: DROP, stale reply arrives
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || mem_re !== 1'b0) begin
      bad++;
      $display("FAIL rdw_flush got v=%b re=%b exp v=0 re=0", valid_o, mem_re);
    end
    next_cycle();                         // C9: refetch at aligned target
    @(negedge clk);
    total++;
    if (mem_re !== 1'b1 || mem_addr_o !== 32'h100 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rdw_refetch got re=%b addr=%h v=%b exp re=1 addr=00000100 v=0", mem_re, mem_addr_o, valid_o);
    end
    for (int k = 10; k < 12; k++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (valid_o !== 1'b0) begin
        bad++;
        $display("FAIL rdw_no_stale cyc=%0d got v=%b exp v=0", k, valid_o);
      end
    end
    next_cycle();                         // C12
    @(negedge clk);
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== inst_of(32'h100)) begin
      bad++;
      $display("FAIL rdw_first got v=%b pc=%h inst=%h exp v=1 pc=00000100 inst=%h", valid_o, pc_o, inst_o, inst_of(32'h100));
    end
    next_cycle();
  endtask

  // Redirect in the same cycle as the reply: no DROP, refetch immediately.
  task automatic test_redirect_done();
    do_reset(1'b0, 1'b0);
    repeat (2) next_cycle();              // C2: reply for pc 0 arrives
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    next_cycle();                         // C3
    redirect_i = 1'b0;
    @(negedge clk);
    total++;
    if (mem_re !== 1'b1 || mem_addr_o !== 32'h200 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rdd_refetch got re=%b addr=%h v=%b exp re=1 addr=00000200 v=0", mem_re, mem_addr_o, valid_o);
    end
    next_cycle();                         // C4
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rdd_discard got v=%b exp v=0", valid_o);
    end
    repeat (2) next_cycle();              // C6
    @(negedge clk);
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h200 || inst_o !== inst_of(32'h200)) begin
      bad++;
      $display("FAIL rdd_first got v=%b pc=%h inst=%h exp v=1 pc=00000200 inst=%h", valid_o, pc_o, inst_o, inst_of(32'h200));
    end
    next_cycle();
  endtask

  // Memory port busy: no request and ID starved until it frees up.
  task automatic test_busy();
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (mem_re !== 1'b0 || stallreq !== 1'b1 || valid_o !== 1'b0) begin
        bad++;
        $display("FAIL busy_hold cyc=%0d got re=%b sr=%b v=%b exp re=0 sr=1 v=0", i, mem_re, stallreq, valid_o);
      end
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    total++;
    if (mem_re !== 1'b1 || mem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL busy_release got re=%b addr=%h exp re=1 addr=00000000", mem_re, mem_addr_o);
    end
    repeat (3) next_cycle();
    @(negedge clk);
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== inst_of(32'h0)) begin
      bad++;
      $display("FAIL busy_first got v=%b pc=%h inst=%h exp v=1 pc=00000000", valid_o, pc_o, inst_o);
    end
    next_cycle();
  endtask

  // Reset while waiting; the late reply lands in IDLE and must be ignored.
  task automatic test_reset_wait();
    do_reset(1'b0, 1'b0);
    @(negedge clk);                       // C0: request for pc 0
    total++;
    if (mem_re !== 1'b1) begin
      bad++;
      $display("FAIL rsw_issue got re=%b exp re=1", mem_re);
    end
    next_cycle();                         // C1: WAIT, assert reset
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_re !== 1'b0 || valid_o !== 1'b0 || stallreq !== 1'b0) begin
      bad++;
      $display("FAIL rsw_in_reset got re=%b v=%b sr=%b exp 0/0/0", mem_re, valid_o, stallreq);
    end
    next_cycle();                         // C2: stale reply, new request
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mem_re !== 1'b1 || mem_addr_o !== 32'h0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rsw_restart got re=%b addr=%h v=%b exp re=1 addr=00000000 v=0", mem_re, mem_addr_o, valid_o);
    end
    for (int k = 3; k < 5; k++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (valid_o !== 1'b0) begin
        bad++;
        $display("FAIL rsw_ignored cyc=%0d got v=%b exp v=0", k, valid_o);
      end
    end
    next_cycle();                         // C5
    @(negedge clk);
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== inst_of(32'h0)) begin
      bad++;
      $display("FAIL rsw_first got v=%b pc=%h inst=%h exp v=1 pc=00000000", valid_o, pc_o, inst_o);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_wait();
    test_redirect_done();
    test_busy();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_if_prefetch.md
Name: stage_if_prefetch

Overview:
- Clocked, parametrised successor to the combinational IF stage.
- Runs its own fetch PC and issues instruction reads over the single-port memory handshake (mem_re/mem_busy/mem_done).
- Buffers up to DEPTH fetched instructions, with their PCs, in a prefetch queue.
- Delivers instructions to ID under a valid/stall handshake, and flushes on branch/jump redirect.

Parameters:
- ADDR_W, 32, fetch address / PC width (matches `MemAddrBus).
- INST_W, 32, instruction width (matches `InstBus).
- DEPTH, 4, prefetch queue entries; power of two, >=2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  ID not accepting this cycle.
- redirect_i  in  1  branch/jump taken; flush and refetch.
- redirect_pc_i  in  ADDR_W  new fetch PC; bits [1:0] ignored, treated as 0.
- mem_busy  in  1  memory port occupied; request not accepted.
- mem_done  in  1  one-cycle pulse; mem_data_i valid.
- mem_data_i  in  INST_W  returned instruction.
- mem_re  out  1  read request.
- mem_addr_o  out  ADDR_W  read address.
- pc_o  out  ADDR_W  PC of presented instruction.
- inst_o  out  INST_W  presented instruction.
- valid_o  out  1  pc_o/inst_o valid.
- stallreq  out  1  pipeline stall request to ctrl.

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC; queue emptied; state=IDLE.
  - mem_re=0, mem_addr_o=0, pc_o=0, inst_o=0, valid_o=0, stallreq=0.
  - Reset mid-transaction abandons the request. A mem_done arriving later in IDLE is ignored.
- FSM, registered; states IDLE, WAIT, DROP.
- IDLE:
  - Issue condition: !mem_busy && !redirect_i && (count+inflight < DEPTH).
  - When it holds: mem_re=1 and mem_addr_o=fetch_pc for exactly one cycle; fetch_pc+=4 (wraps modulo 2^ADDR_W); go to WAIT.
  - Otherwise mem_re=0.
- WAIT:
  - mem_done: push {issued PC, mem_data_i}; go to IDLE. Next issue is possible the following cycle.
  - mem_busy alone: hold.
- DROP: the outstanding read is stale. On mem_done discard the data; go to IDLE.
- At most one read outstanding (inflight ∈ {0,1}). The slot is reserved at issue, so a push never overflows.
- Output:
  - Head of queue drives pc_o/inst_o, registered; valid_o = queue non-empty.
  - Pop when valid_o && !stall_i.
  - Push and pop in the same cycle are both honoured; count unchanged.
- stallreq = !valid_o && !rst (ID starved).
- Redirect (highest priority after rst):
  - Queue flushed and valid_o=0 next cycle; fetch_pc=redirect_pc_i & ~3.
  - In WAIT without same-cycle mem_done: go to DROP.
  - In WAIT with same-cycle mem_done: data discarded; go to IDLE.
  - In IDLE: no issue that cycle.
  - Redirect beats a simultaneous pop or push.
- Latency: issue at T, mem_done at T+k, valid_o at T+k+1 (queue empty, no stall).
- Full: count=DEPTH, or count=DEPTH-1 with inflight=1. No issue; fetch_pc held.

Optional Feature:
- Macro IF_BYPASS_EN.
- Defined: when the queue is empty and mem_done arrives in WAIT without redirect_i, the instruction is presented combinationally that cycle (valid_o=1, stallreq=0). If !stall_i it is consumed and not enqueued; otherwise it is enqueued. Latency T+k.
- Undefined: outputs are purely registered from the queue head; latency T+k+1.

Decomposition:
- defines.v gains: state encodings IF_IDLE/IF_WAIT/IF_DROP, INST_BYTES=4, and reuses `MemAddrBus/`InstBus.
- One sub-module, if_fifo: synchronous FIFO, parametrised width (ADDR_W+INST_W) and depth, with a flush input. It exposes count, empty and full; no overflow or underflow on legal use.

Test Plan:
- Reset, mem_busy=0, memory answers 2 cycles after mem_re, stall_i=0 -> mem_addr_o 0,4,8,...; pc_o 0,4,8 with the correct inst_o; no gaps beyond the memory latency.
- stall_i=1 held, DEPTH=4 -> exactly 4 entries queued, mem_re then stays 0, fetch_pc=0x10. Release stall -> 4 pops in consecutive cycles, then fetching resumes at 0x10.
- redirect_i with redirect_pc_i=0x103 while in WAIT -> the returning instruction is dropped, queue emptied, next mem_addr_o=0x100, next valid pc_o=0x100.
- redirect_i in the same cycle as mem_done -> data discarded, no DROP state, next mem_addr_o is the redirect target.
- mem_busy=1 for 5 cycles in IDLE -> mem_re=0, stallreq=1. Busy drops -> request issued next cycle.
- rst asserted in WAIT, then a mem_done 1 cycle later -> ignored; valid_o=0; first post-reset request goes to RESET_PC.
